dadda_mul: RTL and testbench

- Pipelined 16x16 unsigned multiplier built on a Dadda reduction tree, with a carry-in bit added into column 0.
- Produces a truncated 16-bit result plus an overflow flag.
- Used as a datapath arithmetic unit feeding 16-bit result buses; the full 32-bit product is optionally exposed.

---
 rtl/dadda_mul_pkg.sv | 67 ++++++
 rtl/dadda_mul_fa.sv | 12 +
 rtl/dadda_mul.sv | 153 +++++++++++++++
 tb/tb_dadda_mul.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dadda_mul_pkg.sv
// dadda_mul shared constants, row type and tree planning helpers.
// plan() gives per-stage column heights and FA/HA counts for the tree.
package dadda_mul_pkg;

  localparam int W = 16;
  localparam int PW = 2 * W;
  localparam int NST = 6;
  localparam int MAXH = W;

  typedef logic [PW-1:0] pp_row_t;

  // Dadda target heights, stage 0 first
  function automatic int dh(int st);
    int r;
    r = 2;
    case (st)
      0: r = 13;
      1: r = 9;
      2: r = 6;
      3: r = 4;
      4: r = 3;
      default: r = 2;
    endcase
    return r;
  endfunction

  // initial column height: AND terms plus cin in column 0
  function automatic int init_h(int c);
    int h;
    if (c < 0 || c >= PW - 1) return 0;
    h = (c < W) ? c + 1 : PW - 1 - c;
    if (c == 0) h = h + 1;
    return h;
  endfunction

  // kind 0: input height, 1: full adders, 2: half adders
  function automatic int plan(int s, int c, int kind);
    int h [PW];
    int nh [PW];
    int f;
    int ha;
    int e;
    int ci;
    int r;
    r = 0;
    if (c < 0 || c >= PW) return 0;
    for (int i = 0; i < PW; i++) h[i] = init_h(i);
    for (int st = 0; st < NST; st++) begin
      ci = 0;
      for (int i = 0; i < PW; i++) begin
        e = h[i] + ci - dh(st);
        f = (e > 0) ? e / 2 : 0;
        ha = (e > 0) ? e % 2 : 0;
        nh[i] = h[i] - 2 * f - ha + ci;
        ci = f + ha;
        if (st == s && i == c) begin
          r = (kind == 0) ? h[i] :
              (kind == 1) ? f : ha;
        end
      end
      h = nh;
    end
    if (s >= NST && kind == 0) r = h[c];
    return r;
  endfunction

endpackage

// File: rtl/dadda_mul_fa.sv
// dadda_fa: 1-bit full adder cell of the reduction tree.
// Ports: a, b, ci in; s sum, co carry out.
module dadda_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/dadda_mul.sv
// dadda_mul: 2-stage 16x16 Dadda multiplier, P = a*b + cin.
// Ports: clk, rst, in_valid, a, b, cin -> out_valid, sum, carry
// (and prod_hi when DADDA_MUL_FULL_PRODUCT_EN is defined).
module dadda_mul
  import dadda_mul_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef DADDA_MUL_FULL_PRODUCT_EN
  output logic [W-1:0] prod_hi,
`endif
  output logic         out_valid,
  output logic [W-1:0] sum,
  output logic         carry
);

  localparam int LAT = 2;

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         cin_q;
  logic         v0;
  logic         v1;
  pp_row_t      row0;
  pp_row_t      row1;
  pp_row_t      row0_q;
  pp_row_t      row1_q;
  pp_row_t      p;

  // bits[s][c][k]: k-th bit of column c entering stage s
  logic bits [0:NST][0:PW-1][0:MAXH-1];

  genvar gi, gj, gs, gc, gk;

  for (gi = 0; gi < W; gi++) begin : g_ppi
    for (gj = 0; gj < W; gj++) begin : g_ppj
      localparam int C = gi + gj;
      localparam int K = gi - ((C > W - 1) ? C - (W - 1) : 0);
      assign bits[0][C][K] = a_q[gj] & b_q[gi];
    end
  end
  assign bits[0][0][1] = cin_q;

  for (gs = 0; gs < NST; gs++) begin : g_st
    for (gc = 0; gc < PW; gc++) begin : g_col
      localparam int H   = plan(gs, gc, 0);
      localparam int F   = plan(gs, gc, 1);
      localparam int HA  = plan(gs, gc, 2);
      localparam int CI  = plan(gs, gc - 1, 1)
                         + plan(gs, gc - 1, 2);
      localparam int HN  = plan(gs, gc + 1, 0);
      localparam int FN  = plan(gs, gc + 1, 1);
      localparam int HAN = plan(gs, gc + 1, 2);
      // carries land after sums and pass-throughs of c+1
      localparam int CB  = HN - 2 * FN - HAN;
      localparam int PT  = H - 3 * F - 2 * HA;

      for (gk = 0; gk < F; gk++) begin : g_fa
        if (gc < PW - 1) begin : g_full
          dadda_fa u_fa (
            .a  (bits[gs][gc][3*gk]),
            .b  (bits[gs][gc][3*gk+1]),
            .ci (bits[gs][gc][3*gk+2]),
            .s  (bits[gs+1][gc][gk]),
            .co (bits[gs+1][gc+1][CB+gk])
          );
        end else begin : g_top
          assign bits[gs+1][gc][gk] =
            bits[gs][gc][3*gk] ^ bits[gs][gc][3*gk+1]
            ^ bits[gs][gc][3*gk+2];
        end
      end

      for (gk = 0; gk < HA; gk++) begin : g_ha
        localparam int X = 3 * F + 2 * gk;
        assign bits[gs+1][gc][F+gk] =
          bits[gs][gc][X] ^ bits[gs][gc][X+1];
        if (gc < PW - 1) begin : g_hc
          assign bits[gs+1][gc+1][CB+F+gk] =
            bits[gs][gc][X] & bits[gs][gc][X+1];
        end
      end

      for (gk = 0; gk < PT; gk++) begin : g_pt
        assign bits[gs+1][gc][F+HA+gk] =
          bits[gs][gc][3*F+2*HA+gk];
      end

      if (CI < 0) begin : g_never
        assign bits[gs+1][gc][0] = 1'b0;
      end
    end
  end

  for (gc = 0; gc < PW; gc++) begin : g_rows
    localparam int HF = plan(NST, gc, 0);
    if (HF >= 1) begin : g_r0
      assign row0[gc] = bits[NST][gc][0];
    end else begin : g_z0
      assign row0[gc] = 1'b0;
    end
    if (HF >= 2) begin : g_r1
      assign row1[gc] = bits[NST][gc][1];
    end else begin : g_z1
      assign row1[gc] = 1'b0;
    end
  end

  assign p = row0_q + row1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      v0        <= 1'b0;
      row0_q    <= '0;
      row1_q    <= '0;
      v1        <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
`ifdef DADDA_MUL_FULL_PRODUCT_EN
      prod_hi   <= '0;
`endif
    end else begin
      v0        <= in_valid;
      v1        <= v0;
      out_valid <= v1;
      if (in_valid) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
      end
      if (v0) begin
        row0_q <= row0;
        row1_q <= row1;
      end
      if (v1) begin
        sum   <= p[W-1:0];
        carry <= |p[PW-1:W];
`ifdef DADDA_MUL_FULL_PRODUCT_EN
        prod_hi <= p[PW-1:W];
`endif
      end
    end
  end

endmodule

// File: tb/tb_dadda_mul.sv
// tb_dadda_mul: scoreboard bench for dadda_mul against a*b+cin.
// Directed vectors, streaming, mid-flight reset, random traffic.
module tb_dadda_mul;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic [15:0] sum;
  logic        carry;
`ifdef DADDA_MUL_FULL_PRODUCT_EN
  logic [15:0] prod_hi;
`endif

  dadda_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef DADDA_MUL_FULL_PRODUCT_EN
    .prod_hi   (prod_hi),
`endif
    .out_valid (out_valid),
    .sum       (sum),
    .carry     (carry)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic [15:0] hi;
    int          iss;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // reference: full product as plain 64-bit arithmetic
  task automatic issue(input logic [15:0] x,
                       input logic [15:0] y,
                       input logic ci);
    longint unsigned pr;
    exp_t e;
    pr = longint'(x) * longint'(y) + longint'(ci);
    e.s   = pr[15:0];
    e.hi  = pr[31:16];
    e.c   = (pr[31:16] != 0);
    e.iss = cyc + 1;
    q.push_back(e);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string nm);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL %s: out_valid=%b sum=%h carry=%b want 0/0000/0",
               nm, out_valid, sum, carry);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected: out_valid=1 sum=%h with none pending",
                 sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (sum !== e.s || carry !== e.c || cyc != e.iss + 2) begin
          errors++;
          $display("FAIL result: sum=%h carry=%b cyc=%0d want %h %b %0d",
                   sum, carry, cyc, e.s, e.c, e.iss + 2);
        end
`ifdef DADDA_MUL_FULL_PRODUCT_EN
        checks++;
        if (prod_hi !== e.hi) begin
          errors++;
          $display("FAIL prod_hi: got %h want %h", prod_hi, e.hi);
        end
`endif
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;

    issue(16'hCC2A, 16'hAA55, 1'b0);
    idle(3);
    issue(16'h0F6A, 16'h005F, 1'b0);
    idle(3);
    issue(16'h0003, 16'h0005, 1'b1);
    issue(16'h0000, 16'h1234, 1'b1);
    idle(3);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    idle(4);

    issue(16'hCC2A, 16'hAA55, 1'b0);
    issue(16'h0F6A, 16'h005F, 1'b0);
    issue(16'h0003, 16'h0005, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    idle(5);

    issue(16'h1234, 16'h5678, 1'b1);
    issue(16'hFFFF, 16'h0002, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'hBEEF;
    b = 16'hCAFE;
    @(posedge clk);
    #1;
    q.delete();
    in_valid = 1'b0;
    check_zero("mid_reset");
    rst = 1'b0;
    idle(6);

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) != 0)
        issue(16'($urandom), 16'($urandom), 1'($urandom));
      else
        idle(1);
    end
    idle(1);

    budget = 20;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results missing, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
